hilo_md_unit: RTL and testbench
===============================

// Module: hilo_md_unit
// PURPOSE
//  Execute-stage responder for the decoder's MULT/DIV/MTHL/MFHL request vectors: owns HI/LO,
//  performs mult/multu (fixed latency) and div/divu (iterative, DATA_W cycles).
//  Raises md_stall so the EX stage holds later HI/LO-touching instructions while busy.
//  Sits beside the ALU in EX; hilo_rdata feeds the EX result mux for mfhi/mflo.
// PARAMETERS
//  DATA_W   32  operand and HI/LO width; divide iteration count equals DATA_W
//  MUL_LAT  1   cycles the MUL state is held before HI/LO are written (>=1)
// PORTS
//  clk          in   1       clock; all state rises on posedge
//  resetn       in   1       async active-low reset
//  md_en        in   1       EX instruction valid this cycle; all requests ignored when 0
//  md_cancel    in   1       exception flush: abort any running op, no HI/LO write
//  MULT         in   2       [1]=multu [0]=mult (decoder encoding)
//  DIV          in   2       [1]=divu  [0]=div
//  MTHL         in   2       [1]=mthi  [0]=mtlo
//  MFHL         in   2       [1]=mfhi  [0]=mflo
//  rs_data      in   DATA_W  operand A / dividend / mthi-mtlo source
//  rt_data      in   DATA_W  operand B / divisor
//  md_stall     out  1       hold EX: md_busy & md_en & (any of MULT|DIV|MTHL|MFHL nonzero)
//  md_busy      out  1       state != IDLE
//  hilo_rdata   out  DATA_W  MFHL[1] ? HI : MFHL[0] ? LO : 0 (combinational, current regs)
//  hi, lo       out  DATA_W  architectural HI/LO registers
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, counter=0, md_busy=md_stall=0; async assert, sync release.
//  Accept: request accepted only when state==IDLE, md_en=1, md_cancel=0. A stalled request
//   is not accepted; the EX stage re-presents it. Accepting instruction itself is not stalled.
//  Priority if decoder violates one-hot: DIV > MULT > MTHL; MFHL is read-only, never blocked
//   in IDLE.
//  States: IDLE, MUL, DIV.
//   IDLE -MULT-> MUL: latch rs/rt, signed flag = MULT[0]. MUL held MUL_LAT cycles; 64-bit
//    product written {HI,LO} on last MUL edge; -> IDLE. mult at T: busy T+1..T+MUL_LAT.
//   IDLE -DIV-> DIV: latch |rs|,|rt| (abs only when DIV[0]), sign_q=rs[MSB]^rt[MSB],
//    sign_r=rs[MSB]. Restoring radix-2, one quotient bit per cycle, counter 0..DATA_W-1;
//    on counter==DATA_W-1 edge: LO=sign_q?-q:q, HI=sign_r?-r:r; -> IDLE.
//    div at T: busy T+1..T+32 (DATA_W=32); mflo at T+33 reads result without stall.
//   MTHL in IDLE: HI (or LO) <= rs_data at the edge ending the cycle; mfhi same cycle reads
//    old value, next cycle reads new.
//  Divide by zero: no trap; unsigned gives LO=all-ones, HI=dividend; signed applies the
//   sign rules above to those magnitudes (e.g. div -5/0 -> LO=1, HI=-5).
//  Signed overflow 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  Product is full 2*DATA_W with signed/unsigned extension per flag; no truncation.
//  md_cancel: MUL/DIV -> IDLE immediately, HI/LO unchanged; same-cycle request dropped.
//  Reset mid-operation: abort, HI=LO=0.
// STRUCTURE
//  Shared package: request-bit indices (unsigned=1, signed=0), FSM state encoding,
//   DATA_W default.
//  Sub-module md_div_core: iterative restoring divider (start, dividend, divisor -> done,
//   q, r), unsigned magnitudes only; sign fix-up and HI/LO write stay in hilo_md_unit.
//  Multiplier: behavioural '*' on sign/zero-extended 2*DATA_W operands, registered.
// TESTING
//  mthi 0x1234, next cycle mfhi -> hilo_rdata=0x1234; same-cycle mfhi -> old value 0.
//  mult 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=1, LO=0xFFFFFFFE;
//   busy exactly MUL_LAT cycles.
//  div -7/2 -> LO=-3, HI=-1; divu 100/7 -> LO=14, HI=2; busy 32 cycles; mflo issued
//   at T+1 stalls until T+33.
//  div 0x80000000/-1 -> LO=0x80000000, HI=0; divu 9/0 -> LO=0xFFFFFFFF, HI=9.
//  md_cancel at counter 10 of a div -> IDLE next cycle, HI/LO keep prior values,
//   md_stall drops.
//  resetn low mid-div -> md_busy=0, HI=LO=0 asynchronously; new div after release completes.

Source files
------------

// File: rtl/hilo_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: request-bit positions,
// FSM state encoding and the default datapath width.
package hilo_md_pkg;

  localparam int unsigned MD_DATA_W = 32;

  // Decoder request vectors: bit 0 is the signed / LO variant, bit 1 the unsigned / HI variant.
  localparam int unsigned REQ_SIGNED   = 0;
  localparam int unsigned REQ_UNSIGNED = 1;
  localparam int unsigned REQ_LO       = 0;
  localparam int unsigned REQ_HI       = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/hilo_md_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle,
// DATA_W cycles per divide; q/r are the final-step values while done is high.
module md_div_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);

  localparam int unsigned CW = $clog2(DATA_W);

  logic              running;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   diff;
  logic              take;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;

  // The dividend is shifted out of quo's MSB while quotient bits fill in from the LSB.
  always_comb begin
    rem_shift = {rem, quo[DATA_W-1]};
    diff      = rem_shift - {1'b0, dvs};
    take      = ~diff[DATA_W];
    rem_nxt   = take ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    quo_nxt   = {quo[DATA_W-2:0], take};
  end

  assign done = running && (count == CW'(DATA_W - 1));
  assign q    = quo_nxt;
  assign r    = rem_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running <= 1'b0;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else if (abort) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
    end else if (running) begin
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      count <= done ? '0 : count + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_md_unit.sv
// EX-stage HI/LO owner: mult/multu with fixed latency, div/divu via the iterative
// core, mthi/mtlo writes and mfhi/mflo reads, with a stall for the EX stage while busy.
module hilo_md_unit
  import hilo_md_pkg::*;
#(
  parameter int unsigned DATA_W  = MD_DATA_W,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              md_en,
  input  logic              md_cancel,
  input  logic [1:0]        MULT,
  input  logic [1:0]        DIV,
  input  logic [1:0]        MTHL,
  input  logic [1:0]        MFHL,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              md_stall,
  output logic              md_busy,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e           state_q;
  md_state_e           state_d;
  logic                accept;
  logic                start_div;
  logic                start_mul;
  logic                do_mt;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                mul_signed;
  logic [MCW-1:0]      mul_cnt;
  logic                mul_last;
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] product;
  logic                div_signed_op;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic                sign_q;
  logic                sign_r;
  logic                div_done;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   div_r;

  // DIV outranks MULT outranks MTHL when the decoder asserts more than one vector.
  assign accept    = (state_q == ST_IDLE) && md_en && !md_cancel;
  assign start_div = accept && (DIV != 2'b00);
  assign start_mul = accept && (DIV == 2'b00) && (MULT != 2'b00);
  assign do_mt     = accept && (DIV == 2'b00) && (MULT == 2'b00) && (MTHL != 2'b00);

  assign div_signed_op = DIV[REQ_SIGNED];
  assign rs_mag = (div_signed_op && rs_data[DATA_W-1]) ? -rs_data : rs_data;
  assign rt_mag = (div_signed_op && rt_data[DATA_W-1]) ? -rt_data : rt_data;

  assign ext_a   = mul_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
  assign ext_b   = mul_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
  assign product = ext_a * ext_b;

  assign mul_last = (mul_cnt == MCW'(MUL_LAT - 1));

  md_div_core #(
    .DATA_W(DATA_W)
  ) u_div_core (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start_div),
    .abort    (md_cancel),
    .dividend (rs_mag),
    .divisor  (rt_mag),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_div) begin
          state_d = ST_DIV;
        end else if (start_mul) begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (md_cancel || mul_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (md_cancel || div_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md_busy  = (state_q != ST_IDLE);
    md_stall = md_busy && md_en && ((MULT | DIV | MTHL | MFHL) != 2'b00);
    if (MFHL[REQ_HI]) begin
      hilo_rdata = hi;
    end else if (MFHL[REQ_LO]) begin
      hilo_rdata = lo;
    end else begin
      hilo_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      mul_cnt    <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
    end else if (start_mul) begin
      op_a       <= rs_data;
      op_b       <= rt_data;
      mul_signed <= MULT[REQ_SIGNED];
      mul_cnt    <= '0;
    end else if (start_div) begin
      sign_q <= div_signed_op && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
      sign_r <= div_signed_op && rs_data[DATA_W-1];
    end else if (state_q == ST_MUL) begin
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  // A cancel arriving on the final MUL/DIV cycle suppresses the HI/LO write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if ((state_q == ST_MUL) && !md_cancel && mul_last) begin
      hi <= product[2*DATA_W-1:DATA_W];
      lo <= product[DATA_W-1:0];
    end else if ((state_q == ST_DIV) && !md_cancel && div_done) begin
      lo <= sign_q ? -div_q : div_q;
      hi <= sign_r ? -div_r : div_r;
    end else if (do_mt) begin
      if (MTHL[REQ_HI]) begin
        hi <= rs_data;
      end
      if (MTHL[REQ_LO]) begin
        lo <= rs_data;
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference of HI/LO and busy timing.
module tb_hilo_md_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned ML = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          md_en;
  logic          md_cancel;
  logic [1:0]    MULT;
  logic [1:0]    DIV;
  logic [1:0]    MTHL;
  logic [1:0]    MFHL;
  logic [W-1:0]  rs_data;
  logic [W-1:0]  rt_data;
  logic          md_stall;
  logic          md_busy;
  logic [W-1:0]  hilo_rdata;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  hilo_md_unit #(
    .DATA_W  (W),
    .MUL_LAT (ML)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .md_en      (md_en),
    .md_cancel  (md_cancel),
    .MULT       (MULT),
    .DIV        (DIV),
    .MTHL       (MTHL),
    .MFHL       (MFHL),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .md_stall   (md_stall),
    .md_busy    (md_busy),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {HI, LO}.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint p;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) begin
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {r, q};
  endfunction

  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      if (md_cancel) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end
    end else if (md_en && !md_cancel) begin
      if (DIV != 2'b00) begin
        {p_hi, p_lo} <= ref_div(rs_data, rt_data, DIV[0]);
        m_left <= W;
      end else if (MULT != 2'b00) begin
        {p_hi, p_lo} <= ref_mul(rs_data, rt_data, MULT[0]);
        m_left <= ML;
      end else begin
        if (MTHL[1]) m_hi <= rs_data;
        if (MTHL[0]) m_lo <= rs_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", {31'b0, md_busy}, {31'b0, (m_left > 0)});
      check("stall", {31'b0, md_stall},
            {31'b0, (m_left > 0) && md_en && ((MULT | DIV | MTHL | MFHL) != 2'b00)});
      check("rdata", hilo_rdata, MFHL[1] ? m_hi : (MFHL[0] ? m_lo : 32'h0));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic clr();
    md_en = 1'b0; md_cancel = 1'b0;
    MULT = 2'b00; DIV = 2'b00; MTHL = 2'b00; MFHL = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] mu, input logic [1:0] dv, input logic [1:0] mt,
                       input logic [31:0] a, input logic [31:0] b);
    clr();
    md_en = 1'b1; MULT = mu; DIV = dv; MTHL = mt;
    rs_data = a; rt_data = b;
    tick();
    clr();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_busy && n < 200) begin
      n++;
      tick();
    end
    check("idle_timeout", {31'b0, md_busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    clr();
    rs_data = '0;
    rt_data = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, md_busy}, 32'd0);
    resetn = 1'b1;
    tick();
    chk_on = 1'b1;

    // mthi with same-cycle and next-cycle mfhi
    md_en = 1'b1; MTHL = 2'b10; MFHL = 2'b10; rs_data = 32'h1234;
    #1 check("mfhi_same_cycle", hilo_rdata, 32'h0);
    tick();
    MTHL = 2'b00;
    #1 check("mfhi_next_cycle", hilo_rdata, 32'h1234);
    clr();
    tick();

    issue(2'b01, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("mult_busy_cycles", n, ML);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    issue(2'b10, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_busy_cycles", n, ML);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7/2 with mflo presented from the next cycle on
    clr();
    md_en = 1'b1; DIV = 2'b01; rs_data = -32'd7; rt_data = 32'd2;
    tick();
    clr();
    md_en = 1'b1; MFHL = 2'b01;
    n = 0;
    while (md_stall && n < 200) begin
      n++;
      tick();
    end
    check("div_stall_cycles", n, 32);
    check("div_mflo", hilo_rdata, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    clr();
    tick();

    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_busy_cycles", n, 32);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(2'b00, 2'b01, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    issue(2'b00, 2'b10, 2'b00, 32'd9, 32'd0);
    wait_idle(n);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi, 32'd9);

    issue(2'b00, 2'b01, 2'b00, -32'd5, 32'd0);
    wait_idle(n);
    check("div_zero_lo", lo, 32'd1);
    check("div_zero_hi", hi, 32'hFFFF_FFFB);

    // cancel at counter 10
    issue(2'b00, 2'b01, 2'b00, 32'd1000, 32'd3);
    repeat (10) tick();
    md_cancel = 1'b1; md_en = 1'b1; MFHL = 2'b01;
    #1 check("cancel_stall_pre", {31'b0, md_stall}, 32'd1);
    tick();
    md_cancel = 1'b0;
    #1;
    check("cancel_busy", {31'b0, md_busy}, 32'd0);
    check("cancel_stall", {31'b0, md_stall}, 32'd0);
    check("cancel_hi", hi, 32'hFFFF_FFFB);
    check("cancel_lo", lo, 32'd1);
    clr();
    tick();

    // reset mid-divide, then a fresh divide
    issue(2'b00, 2'b01, 2'b00, 32'd1000, 32'd3);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, md_busy}, 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    wait_idle(n);
    check("post_rst_lo", lo, 32'd14);
    check("post_rst_hi", hi, 32'd2);

    repeat (4000) begin
      resetn    = ($urandom_range(0, 999) != 0);
      md_en     = ($urandom_range(0, 9) != 0);
      md_cancel = ($urandom_range(0, 39) == 0);
      DIV       = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      MULT      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      MTHL      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      MFHL      = 2'($urandom_range(0, 3));
      rs_data   = pick_op();
      rt_data   = pick_op();
      tick();
    end

    resetn = 1'b1;
    clr();
    repeat (3) tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
